// File: rtl/riscv_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester IDs and
// the default burst limit.
package riscv_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_C = 2'd1,
        ST_OWN_L = 2'd2
    } arb_state_e;

    typedef enum logic {
        ID_CORE   = 1'b0,
        ID_LOADER = 1'b1
    } req_id_e;

    localparam int unsigned DEFAULT_MAX_BURST = 8;
    localparam int unsigned BURST_CNT_W       = 8;

    function automatic req_id_e other_id(input req_id_e id);
        return (id == ID_CORE) ? ID_LOADER : ID_CORE;
    endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// Locked-burst beat counter for dmem_arbiter; also remembers which requester
// is owed the next IDLE tie after a forced release.
module arb_burst_counter
    import riscv_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    locked_beat,
    input  logic    from_idle,
    input  req_id_e winner,
    input  logic    tie_resolved,
    output logic    force_release,
    output logic    favor_valid,
    output req_id_e favor_id
);

    localparam logic [BURST_CNT_W-1:0] MAX_CNT = BURST_CNT_W'(MAX_BURST);

    logic [BURST_CNT_W-1:0] count_q, count_d, count_inc;
    logic                   favor_valid_q, favor_valid_d;
    req_id_e                favor_id_q, favor_id_d;

    always_comb begin
        // A new burst starts at 1; the count saturates rather than wrapping.
        if (from_idle) begin
            count_inc = BURST_CNT_W'(1);
        end else if (count_q == '1) begin
            count_inc = count_q;
        end else begin
            count_inc = count_q + BURST_CNT_W'(1);
        end

        force_release = locked_beat && (count_inc >= MAX_CNT);
        count_d       = (locked_beat && !force_release) ? count_inc : '0;

        favor_valid_d = favor_valid_q;
        favor_id_d    = favor_id_q;
        if (tie_resolved) begin
            favor_valid_d = 1'b0;
        end
        if (force_release) begin
            favor_valid_d = 1'b1;
            favor_id_d    = other_id(winner);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q       <= '0;
            favor_valid_q <= 1'b0;
            favor_id_q    <= ID_CORE;
        end else begin
            count_q       <= count_d;
            favor_valid_q <= favor_valid_d;
            favor_id_q    <= favor_id_d;
        end
    end

    assign favor_valid = favor_valid_q;
    assign favor_id    = favor_id_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core/loader) arbiter onto a single data memory with locked bursts.
// Define ARB_ROUND_ROBIN_EN to resolve IDLE ties round-robin instead of core-first.
module dmem_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic              c_lock,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_e state_q, state_d;
    req_id_e    last_q, last_d;
    logic       c_rvalid_q, c_rvalid_d;
    logic       l_rvalid_q, l_rvalid_d;

    logic       gnt, tie, tie_resolved, win_lock, win_we;
    logic       force_release, favor_valid;
    req_id_e    winner, tie_winner, favor_id;

    // A pending forced release overrides the configured tie policy.
    always_comb begin
        if (favor_valid) begin
            tie_winner = favor_id;
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            tie_winner = other_id(last_q);
`else
            tie_winner = ID_CORE;
`endif
        end
    end

    always_comb begin
        tie    = c_req && l_req;
        gnt    = 1'b0;
        winner = ID_CORE;
        case (state_q)
            ST_IDLE: begin
                if (tie) begin
                    gnt    = 1'b1;
                    winner = tie_winner;
                end else if (c_req) begin
                    gnt    = 1'b1;
                    winner = ID_CORE;
                end else if (l_req) begin
                    gnt    = 1'b1;
                    winner = ID_LOADER;
                end
            end
            ST_OWN_C: begin
                gnt    = c_req;
                winner = ID_CORE;
            end
            ST_OWN_L: begin
                gnt    = l_req;
                winner = ID_LOADER;
            end
            default: begin
                gnt = 1'b0;
            end
        endcase
        if (!reset) begin
            gnt = 1'b0;
        end

        win_lock     = (winner == ID_CORE) ? c_lock : l_lock;
        win_we       = (winner == ID_CORE) ? c_we : l_we;
        tie_resolved = gnt && tie && (state_q == ST_IDLE);
    end

    // Split from the grant logic so the counter's release flag feeds forward only.
    always_comb begin
        state_d = ST_IDLE;
        if (gnt && win_lock && !force_release) begin
            state_d = (winner == ID_CORE) ? ST_OWN_C : ST_OWN_L;
        end
        last_d     = gnt ? winner : last_q;
        c_rvalid_d = gnt && (winner == ID_CORE) && !win_we;
        l_rvalid_d = gnt && (winner == ID_LOADER) && !win_we;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            last_q     <= ID_LOADER;
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            c_rvalid_q <= c_rvalid_d;
            l_rvalid_q <= l_rvalid_d;
        end
    end

    arb_burst_counter #(
        .MAX_BURST(MAX_BURST)
    ) u_burst_counter (
        .clk          (clk),
        .reset        (reset),
        .locked_beat  (gnt && win_lock),
        .from_idle    (state_q == ST_IDLE),
        .winner       (winner),
        .tie_resolved (tie_resolved),
        .force_release(force_release),
        .favor_valid  (favor_valid),
        .favor_id     (favor_id)
    );

    // Read data is gated during reset so a read in flight never surfaces.
    always_comb begin
        c_gnt    = gnt && (winner == ID_CORE);
        l_gnt    = gnt && (winner == ID_LOADER);
        m_en     = gnt;
        m_we     = gnt && win_we;
        m_addr   = '0;
        m_wdata  = '0;
        if (gnt) begin
            m_addr  = (winner == ID_CORE) ? c_addr : l_addr;
            m_wdata = (winner == ID_CORE) ? c_wdata : l_wdata;
        end
        c_rvalid = c_rvalid_q && reset;
        l_rvalid = l_rvalid_q && reset;
        c_rdata  = c_rvalid ? m_rdata : '0;
        l_rdata  = l_rvalid ? m_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic checked every cycle against a transaction-level model.
module tb_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0, c_lock = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_wdata = '0;
    logic          c_gnt, c_rvalid, l_gnt, l_rvalid, m_en, m_we;
    logic [DW-1:0] c_rdata, l_rdata, m_wdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rdata = '0;

    int n_pass = 0;
    int n_checks = 0;

    // Memory seen by the DUT, and the model's own copy of it.
    logic [DW-1:0] ram [16];
    logic [DW-1:0] mdl_mem [16];

    // Model state: owner/last/favor/rd use 0=none, 1=core, 2=loader.
    int            mdl_owner = 0;
    int            mdl_beats = 0;
    int            mdl_last = 2;
    int            mdl_favor = 0;
    int            mdl_rd = 0;
    logic [DW-1:0] mdl_rdv = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_BURST(MB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .c_req   (c_req),
        .c_we    (c_we),
        .c_lock  (c_lock),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_gnt   (c_gnt),
        .c_rvalid(c_rvalid),
        .c_rdata (c_rdata),
        .l_req   (l_req),
        .l_we    (l_we),
        .l_lock  (l_lock),
        .l_addr  (l_addr),
        .l_wdata (l_wdata),
        .l_gnt   (l_gnt),
        .l_rvalid(l_rvalid),
        .l_rdata (l_rdata),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata)
    );

    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) ram[m_addr[5:2]] <= m_wdata;
            else      m_rdata <= ram[m_addr[5:2]];
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_cycle();
        int            win;
        logic          w_we, w_lock;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_data;

        check_output("mutex", {63'd0, c_gnt && l_gnt}, 64'd0);
        check_output("m_en_or", {63'd0, m_en}, {63'd0, c_gnt || l_gnt});

        if (!reset) begin
            check_output("rst_outs", {58'd0, c_gnt, l_gnt, m_en, m_we, c_rvalid, l_rvalid}, 64'd0);
            check_output("rst_bus", {c_rdata | l_rdata, m_addr | m_wdata}, 64'd0);
            mdl_owner = 0; mdl_beats = 0; mdl_last = 2; mdl_favor = 0; mdl_rd = 0;
            return;
        end

        check_output("rvalid", {62'd0, c_rvalid, l_rvalid}, {62'd0, mdl_rd == 1, mdl_rd == 2});
        check_output("c_rdata", c_rdata, (mdl_rd == 1) ? mdl_rdv : '0);
        check_output("l_rdata", l_rdata, (mdl_rd == 2) ? mdl_rdv : '0);

        win = 0;
        if (mdl_owner == 1)      win = c_req ? 1 : 0;
        else if (mdl_owner == 2) win = l_req ? 2 : 0;
        else if (c_req && l_req) begin
            if (mdl_favor != 0) win = mdl_favor;
            else                win = RR_MODE ? 3 - mdl_last : 1;
            mdl_favor = 0;
        end
        else if (c_req) win = 1;
        else if (l_req) win = 2;

        w_we   = (win == 1) ? c_we : (win == 2) ? l_we : 1'b0;
        w_lock = (win == 1) ? c_lock : l_lock;
        w_addr = (win == 1) ? c_addr : (win == 2) ? l_addr : '0;
        w_data = (win == 1) ? c_wdata : (win == 2) ? l_wdata : '0;

        check_output("gnt", {62'd0, c_gnt, l_gnt}, {62'd0, win == 1, win == 2});
        check_output("m_ctrl", {62'd0, m_en, m_we}, {62'd0, win != 0, w_we});
        check_output("m_addr", m_addr, w_addr);
        check_output("m_wdata", m_wdata, w_data);

        mdl_rd = (win != 0 && !w_we) ? win : 0;
        if (win != 0) begin
            mdl_rdv = mdl_mem[w_addr[5:2]];
            if (w_we) mdl_mem[w_addr[5:2]] = w_data;
            mdl_last = win;
            if (w_lock) begin
                mdl_beats = (mdl_owner == 0) ? 1 : mdl_beats + 1;
                if (mdl_beats >= MB) begin
                    mdl_owner = 0; mdl_beats = 0; mdl_favor = 3 - win;
                end else begin
                    mdl_owner = win;
                end
            end else begin
                mdl_owner = 0; mdl_beats = 0;
            end
        end else begin
            mdl_owner = 0; mdl_beats = 0;
        end
    endtask

    always @(negedge clk) begin
        #2;
        model_cycle();
    end

    task automatic apply_stimulus(input logic rst,
                                  input logic cr, input logic cw, input logic ck,
                                  input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                                  input logic lr, input logic lw, input logic lk,
                                  input logic [AW-1:0] la, input logic [DW-1:0] ld);
        @(negedge clk);
        reset = rst;
        c_req = cr; c_we = cw; c_lock = ck; c_addr = ca; c_wdata = cd;
        l_req = lr; l_we = lw; l_lock = lk; l_addr = la; l_wdata = ld;
        #3;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram[i]     = 32'hA500_0000 | 32'(i);
            mdl_mem[i] = 32'hA500_0000 | 32'(i);
        end
        ram[0]     = 32'hDEAD_BEEF;
        mdl_mem[0] = 32'hDEAD_BEEF;

        // Reset with both requesting: nothing may be granted.
        apply_stimulus(0, 1, 0, 0, 32'h4, 0, 1, 0, 0, 32'h4, 0);
        check_output("rst_no_gnt", {62'd0, c_gnt, l_gnt}, 64'd0);
        apply_stimulus(0, 1, 0, 0, 32'h4, 0, 1, 0, 0, 32'h4, 0);

        // Ties after reset: core first, then policy-dependent.
        apply_stimulus(1, 1, 0, 0, 32'h4, 0, 1, 0, 0, 32'h4, 0);
        check_output("tie_first_c", c_gnt, 1);
        apply_stimulus(1, 1, 0, 0, 32'h4, 0, 1, 0, 0, 32'h4, 0);
        check_output("tie_second_c", c_gnt, RR_MODE ? 0 : 1);
        check_output("tie_second_l", l_gnt, RR_MODE ? 1 : 0);
        apply_stimulus(1, 1, 0, 0, 32'h4, 0, 1, 0, 0, 32'h4, 0);
        check_output("tie_third_c", c_gnt, 1);

        // Single core read of 0x40.
        apply_stimulus(1, 1, 0, 0, 32'h40, 0, 0, 0, 0, 0, 0);
        check_output("read_gnt", c_gnt, 1);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("read_rvalid", c_rvalid, 1);
        check_output("read_rdata", c_rdata, 32'hDEAD_BEEF);
        check_output("read_l_rvalid", l_rvalid, 0);

        // Loader write of 0x12345678 to 0x100.
        apply_stimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 32'h100, 32'h1234_5678);
        check_output("wr_ctrl", {m_en, m_we, l_gnt}, 3'b111);
        check_output("wr_addr", m_addr, 32'h100);
        check_output("wr_data", m_wdata, 32'h1234_5678);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("wr_no_rvalid", {c_rvalid, l_rvalid}, 2'b00);

        // Loader locked burst hits the limit with the core waiting.
        apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 32'h8, 0);
        check_output("burst_beat1", l_gnt, 1);
        for (int b = 2; b <= 4; b++) begin
            apply_stimulus(1, 1, 0, 0, 32'hC, 0, 1, 0, 1, 32'h8, 0);
            check_output("burst_beat_l", {c_gnt, l_gnt}, 2'b01);
        end
        apply_stimulus(1, 1, 0, 0, 32'hC, 0, 1, 0, 1, 32'h8, 0);
        check_output("burst_release", {c_gnt, l_gnt}, 2'b10);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the second cycle of a locked read burst.
        apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 32'h14, 0);
        check_output("mid_beat1", l_gnt, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h14, 0);
        check_output("mid_rst", {l_gnt, l_rvalid, m_en}, 3'b000);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("mid_after", {c_gnt, l_gnt, m_en, c_rvalid, l_rvalid}, 5'b00000);
        check_output("mid_rdata", l_rdata, 0);
        apply_stimulus(1, 1, 0, 0, 32'h4, 0, 1, 0, 0, 32'h4, 0);
        check_output("post_rst_tie", c_gnt, 1);

        // Randomized traffic, biased toward contention and long bursts.
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus($urandom_range(0, 99) != 0,
                           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                           $urandom_range(0, 3) != 0, $urandom, $urandom,
                           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                           $urandom_range(0, 3) != 0, $urandom, $urandom);
        end

        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #10;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
